// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_sb
//  Purpose  : Multi-port register file with a per-register busy scoreboard.
//             Two write ports (port 1 wins on an address collision), NUM_RD
//             combinational read ports and an optional hardwired zero register.
//             A register's busy bit is set at issue (alloc) and cleared at
//             writeback. Same-cycle alloc beats same-cycle clear.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             rd_addr/rd_data     - packed read ports, port k at [k*W +: W]
//             rd_busy             - busy flag of each addressed register
//             wr0_*/wr1_*         - write ports (wr1 has priority)
//             alloc_en/alloc_addr - mark a register pending
//             busy_vec            - whole scoreboard, bit i = register i
//  Options  : define REGFILE_MP_BYPASS_EN for write-to-read forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wr0_en,
   input  logic [ADDR_W-1:0]          wr0_addr,
   input  logic [DATA_W-1:0]          wr0_data,
   input  logic                       wr1_en,
   input  logic [ADDR_W-1:0]          wr1_addr,
   input  logic [DATA_W-1:0]          wr1_data,
   input  logic                       alloc_en,
   input  logic [ADDR_W-1:0]          alloc_addr,
   output logic [(2**ADDR_W)-1:0]     busy_vec
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic              wr0_ok;
   logic              wr1_ok;
   logic              alloc_ok;

   // Register 0 swallows writes and allocations when hardwired to zero.
   assign wr0_ok   = wr0_en   && !((ZERO_REG != 0) && (wr0_addr   == '0));
   assign wr1_ok   = wr1_en   && !((ZERO_REG != 0) && (wr1_addr   == '0));
   assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

   // Clears first, then the set, so a new producer issued in the same cycle
   // as the old one's writeback keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (wr0_en)   busy_nxt[wr0_addr]   = 1'b0;
      if (wr1_en)   busy_nxt[wr1_addr]   = 1'b0;
      if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         busy <= '0;
      end else begin
         // Port 1 is assigned last so it wins an address collision.
         if (wr0_ok) mem[wr0_addr] <= wr0_data;
         if (wr1_ok) mem[wr1_addr] <= wr1_data;
         busy <= busy_nxt;
      end
   end

   assign busy_vec = busy;

   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;
   logic              rbusy;

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      raddr   = '0;
      rdata   = '0;
      rbusy   = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         raddr = rd_addr[k*ADDR_W +: ADDR_W];
         rdata = mem[raddr];
         rbusy = busy[raddr];
`ifdef REGFILE_MP_BYPASS_EN
         if (wr1_en && (wr1_addr == raddr)) begin
            rdata = wr1_data;
         end else if (wr0_en && (wr0_addr == raddr)) begin
            rdata = wr0_data;
         end
         // The pending writeback resolves the hazard unless a new producer
         // claims the register in this very cycle.
         if (((wr1_en && (wr1_addr == raddr)) || (wr0_en && (wr0_addr == raddr)))
             && !(alloc_en && (alloc_addr == raddr))) begin
            rbusy = 1'b0;
         end
`endif
         if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata = '0;
            rbusy = 1'b0;
         end
         rd_data[k*DATA_W +: DATA_W] = rdata;
         rd_busy[k]                  = rbusy;
      end
   end

endmodule
`default_nettype wire

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port successor of the single-write, dual-read register file, for the pipelined/superscalar datapath.
- Configurable data width, depth and read-port count; two write ports with fixed priority; optional hardwired zero register.
- Per-register busy scoreboard: set at issue (allocate), cleared at writeback. ID stage uses it for hazard detection.
- All state updates on posedge clk; reads are combinational.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..8)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all updates on rising edge
rst  in  1  synchronous active-high reset, sampled on posedge clk
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, same packing
rd_busy  out  NUM_RD  busy flag of each addressed register
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
alloc_en  in  1  mark register pending (instruction issued)
alloc_addr  in  ADDR_W  register to mark pending
busy_vec  out  DEPTH  full scoreboard, bit i = register i busy

Behaviour:
- Reset (synchronous): on a posedge with rst=1, all DEPTH registers are cleared to 0 and all busy bits are cleared.
  - rst dominates every write and alloc in that cycle.
  - From the next cycle: rd_data all 0, rd_busy all 0, busy_vec = 0.
  - Reset mid-operation discards pending writes and allocations; no partial state survives.
- Write:
  - On posedge, if wrN_en, then Reg[wrN_addr] <= wrN_data.
  - If both ports target the same address in the same cycle, port 1 data is written.
  - If ZERO_REG=1, writes to address 0 are dropped.
- Read:
  - rd_data[k] = Reg[rd_addr[k]], combinational, zero latency.
  - If ZERO_REG=1 and rd_addr[k]=0, the value is 0.
- Scoreboard update, per posedge with rst=0:
  - A write on either port clears busy[wr_addr].
  - Then, if alloc_en, busy[alloc_addr] is set.
  - So alloc wins over a same-cycle clear of the same register, and the register stays busy for the new producer.
  - Writing a non-busy register is legal; busy stays 0.
  - Allocating an already busy register is legal; busy stays 1 (no counting).
  - ZERO_REG=1: busy[0] is constantly 0; alloc to 0 is ignored.
- rd_busy[k] = busy[rd_addr[k]], subject to the optional bypass below.
- No X propagation: every address in 0..DEPTH-1 is valid; no out-of-range case exists.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If wr1_en and wr1_addr == rd_addr[k], rd_data[k] = wr1_data in the same cycle.
  - Else, if wr0_en and wr0_addr == rd_addr[k], rd_data[k] = wr0_data.
  - rd_busy[k] is masked to 0 when a write to that address is present and no same-cycle alloc hits it.
  - ZERO_REG exclusion still applies.
  - This gives the same-cycle write-then-read visibility the pipeline previously got from a negedge write.
- Undefined: reads return the stored value, so a same-cycle write is visible one cycle later, and rd_busy reflects the registered busy bit only.

Test Plan:
- Reset: rst=1 for 1 cycle after random writes -> all rd_data=0 and busy_vec=0 on the following cycle.
- Dual write collision: wr0 (addr 5, 0x1111_1111) and wr1 (addr 5, 0x2222_2222) in the same cycle -> next cycle rd_addr=5 reads 0x2222_2222.
- Zero register: ZERO_REG=1; write 0xDEAD_BEEF to 0 and alloc 0 -> rd_data=0, busy_vec[0]=0. With ZERO_REG=0 the same stimulus -> reads 0xDEAD_BEEF and busy_vec[0]=1.
- Scoreboard:
  - alloc 7 -> busy_vec[7]=1 next cycle.
  - wr0 to 7 plus alloc 7 in the same cycle -> busy_vec[7] stays 1.
  - A later wr1 to 7 alone -> busy_vec[7]=0.
- Bypass: wr1 (addr 3, 0xA5A5_0003) with rd_addr[0]=3 in the same cycle.
  - Macro defined -> rd_data[0]=0xA5A5_0003 immediately.
  - Macro undefined -> old value this cycle, new value next cycle.
- Multi-port read with NUM_RD=4: distinct addresses 1,2,3,4 preloaded with 0x10..0x13 -> all four ports return their values simultaneously.
